// File: rtl/uart_debounce_pkg.sv
// -----------------------------------------------------------------------------
// uart_debounce_pkg
// Shared types and helpers for the button debounce bank.
//   btn_state_e   : per-channel press-tracking state (RELEASED, PRESSED, LONG)
//   ms_to_cycles  : converts a millisecond interval into clock cycles
//   cnt_width     : bit width able to hold 0..value (never less than 1 bit)
// -----------------------------------------------------------------------------
package uart_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } btn_state_e;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

    // A zero-length interval still needs a 1-bit register to stay legal.
    function automatic int cnt_width(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/uart_debounce_chan.sv
// -----------------------------------------------------------------------------
// uart_debounce_chan
// One button channel: 2-FF synchronizer, debounce counter, and a small FSM
// that generates press / release / long-press / auto-repeat pulses.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   btn_raw         : raw active-low button input (asynchronous)
//   btn_level       : debounced level, active-low
//   btn_level_next  : next-state debounced level (feeds the bank-wide OR)
//   press_pulse     : one cycle on debounced 1->0
//   release_pulse   : one cycle on debounced 0->1
//   long_pulse      : one cycle when the long-press threshold is reached
//   repeat_pulse    : one cycle every REPEAT_CYC cycles while long-pressed
// -----------------------------------------------------------------------------
module uart_debounce_chan
    import uart_debounce_pkg::*;
#(
    parameter int HOLD_CYC   = 5,
    parameter int LONG_CYC   = 20,
    parameter int REPEAT_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_level_next,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DEB_W = cnt_width(HOLD_CYC);
    localparam int HLD_W = cnt_width(LONG_CYC);
    localparam int REP_W = cnt_width(REPEAT_CYC);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(HOLD_CYC - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [HLD_W-1:0] HLD_ONE  = HLD_W'(1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [HLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0] rep_q, rep_d;
    btn_state_e       state_q, state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        s1_d      = btn_raw;
        s2_d      = s1_q;
        level_d   = level_q;
        deb_d     = '0;
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        // Any sample that agrees with the current level restarts the count,
        // so only HOLD_CYC consecutive disagreeing samples commit a change.
        if (s2_q != level_q) begin
            if (deb_q == DEB_LAST) begin
                level_d = s2_q;
            end else begin
                deb_d = deb_q + DEB_ONE;
            end
        end

        press_d   = level_q & ~level_d;
        release_d = ~level_q & level_d;

        // A release commit outranks a long/repeat event due on the same edge.
        if (release_d) begin
            state_d = RELEASED;
            hold_d  = '0;
            rep_d   = '0;
        end else if (press_d) begin
            state_d = PRESSED;
            hold_d  = '0;
            rep_d   = '0;
        end else begin
            case (state_q)
                PRESSED: begin
                    if (hold_q == HLD_LAST) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                        hold_d  = '0;
                        rep_d   = '0;
                    end else begin
                        hold_d = hold_q + HLD_ONE;
                    end
                end
                LONG: begin
                    if (REPEAT_CYC != 0) begin
                        if (rep_q == REP_LAST) begin
                            repeat_d = 1'b1;
                            rep_d    = '0;
                        end else begin
                            rep_d = rep_q + REP_ONE;
                        end
                    end
                end
                default: begin
                    hold_d = '0;
                    rep_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            level_q   <= 1'b1;
            deb_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            state_q   <= RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign btn_level      = level_q;
    assign btn_level_next = level_d;
    assign press_pulse    = press_q;
    assign release_pulse  = release_q;
    assign long_pulse     = long_q;
    assign repeat_pulse   = repeat_q;

endmodule

// File: rtl/uart_debounce_bank.sv
// -----------------------------------------------------------------------------
// uart_debounce_bank
// Bank of NUM_CH independent debounced buttons with press, release,
// long-press and auto-repeat pulses, plus a registered any-pressed flag.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   btn_raw        : raw active-low buttons [NUM_CH]
//   btn_level      : debounced active-low levels [NUM_CH]
//   press_pulse    : debounced press pulses [NUM_CH]
//   release_pulse  : debounced release pulses [NUM_CH]
//   long_pulse     : long-press pulses [NUM_CH]
//   repeat_pulse   : auto-repeat pulses [NUM_CH]
//   any_pressed    : high while any channel is debounced-pressed
// -----------------------------------------------------------------------------
module uart_debounce_bank
    import uart_debounce_pkg::*;
#(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int HOLD_MS   = 5,
    parameter int NUM_CH    = 4,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_raw,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] repeat_pulse,
    output logic              any_pressed
);

    localparam int HOLD_CYC   = ms_to_cycles(CLK_FREQ, HOLD_MS);
    localparam int LONG_CYC   = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int REPEAT_CYC = ms_to_cycles(CLK_FREQ, REPEAT_MS);

    logic [NUM_CH-1:0] level_next;
    logic              any_pressed_q, any_pressed_d;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        uart_debounce_chan #(
            .HOLD_CYC   (HOLD_CYC),
            .LONG_CYC   (LONG_CYC),
            .REPEAT_CYC (REPEAT_CYC)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .btn_raw        (btn_raw[ch]),
            .btn_level      (btn_level[ch]),
            .btn_level_next (level_next[ch]),
            .press_pulse    (press_pulse[ch]),
            .release_pulse  (release_pulse[ch]),
            .long_pulse     (long_pulse[ch]),
            .repeat_pulse   (repeat_pulse[ch])
        );
    end

    // Built from the next-state levels so the flag changes on the same edge
    // as btn_level rather than one cycle behind it.
    always_comb begin
        any_pressed_d = ~&level_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_pressed_q <= 1'b0;
        end else begin
            any_pressed_q <= any_pressed_d;
        end
    end

    assign any_pressed = any_pressed_q;

endmodule

// File: tb/tb_uart_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_uart_debounce_bank
// Directed bench for uart_debounce_bank at CLK_FREQ=1000 (1 cycle per ms).
// Instance dutRep uses REPEAT_MS=8, instance dutNoRep uses REPEAT_MS=0; both
// see the same buttons. Expected event cycles are hand-derived constants.
// Cycle c is the interval following the c-th clock edge after reset release.
// -----------------------------------------------------------------------------
module tb_uart_debounce_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btnRaw = 4'hF;

    logic [3:0] levelA, pressA, releaseA, longA, repeatA;
    logic       anyA;
    logic [3:0] levelB, pressB, releaseB, longB, repeatB;
    logic       anyB;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // 10-unit clock period; all driving and sampling happens 1-2 units after
    // the rising edge so nothing races the DUT flops.
    always #5 clk = ~clk;

    uart_debounce_bank #(
        .CLK_FREQ(1000), .HOLD_MS(5), .NUM_CH(4), .LONG_MS(20), .REPEAT_MS(8)
    ) dutRep (
        .clk(clk), .rst(rst), .btn_raw(btnRaw),
        .btn_level(levelA), .press_pulse(pressA), .release_pulse(releaseA),
        .long_pulse(longA), .repeat_pulse(repeatA), .any_pressed(anyA)
    );

    uart_debounce_bank #(
        .CLK_FREQ(1000), .HOLD_MS(5), .NUM_CH(4), .LONG_MS(20), .REPEAT_MS(0)
    ) dutNoRep (
        .clk(clk), .rst(rst), .btn_raw(btnRaw),
        .btn_level(levelB), .press_pulse(pressB), .release_pulse(releaseB),
        .long_pulse(longB), .repeat_pulse(repeatB), .any_pressed(anyB)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Stimulus table: ch0 long press with repeats, ch1 bounce, ch2 short press,
    // ch0+ch3 simultaneous press, then a reset pulse while ch0 is held long.
    task automatic applyStimulus(input int c);
        logic [3:0] b;
        b = 4'hF;
        if ((c >= 10 && c < 62) || (c >= 110 && c < 130) || (c >= 150 && c < 222)) b[0] = 1'b0;
        if (c >= 10 && c < 13)   b[1] = 1'b0;
        if (c >= 10 && c < 22)   b[2] = 1'b0;
        if (c >= 110 && c < 120) b[3] = 1'b0;
        btnRaw = b;
        rst    = (c >= 180 && c < 182);
    endtask

    function automatic logic [3:0] expLevel(input int c);
        logic [3:0] v;
        v = 4'hF;
        if ((c >= 17 && c <= 68) || (c >= 117 && c <= 136) ||
            (c >= 157 && c <= 179) || (c >= 189 && c <= 228)) v[0] = 1'b0;
        if (c >= 17 && c <= 28)   v[2] = 1'b0;
        if (c >= 117 && c <= 126) v[3] = 1'b0;
        return v;
    endfunction

    function automatic logic [3:0] expPress(input int c);
        logic [3:0] v;
        v = 4'h0;
        v[0] = (c inside {17, 117, 157, 189});
        v[2] = (c == 17);
        v[3] = (c == 117);
        return v;
    endfunction

    function automatic logic [3:0] expRelease(input int c);
        logic [3:0] v;
        v = 4'h0;
        v[0] = (c inside {69, 137, 229});
        v[2] = (c == 29);
        v[3] = (c == 127);
        return v;
    endfunction

    function automatic logic [3:0] expLong(input int c);
        logic [3:0] v;
        v = 4'h0;
        v[0] = (c inside {37, 177, 209});
        return v;
    endfunction

    function automatic logic [3:0] expRepeat(input int c);
        logic [3:0] v;
        v = 4'h0;
        v[0] = (c inside {45, 53, 61, 217, 225});
        return v;
    endfunction

    // Main sequence: reset-state checks, then a per-cycle sweep comparing
    // every output of both instances against the hand-derived event table.
    initial begin
        logic [3:0] lv;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstLevelA",   {28'b0, levelA},   32'hF);
        checkOutput("rstPressA",   {28'b0, pressA},   32'h0);
        checkOutput("rstReleaseA", {28'b0, releaseA}, 32'h0);
        checkOutput("rstLongA",    {28'b0, longA},    32'h0);
        checkOutput("rstRepeatA",  {28'b0, repeatA},  32'h0);
        checkOutput("rstAnyA",     {31'b0, anyA},     32'h0);
        checkOutput("rstLevelB",   {28'b0, levelB},   32'hF);
        checkOutput("rstAnyB",     {31'b0, anyB},     32'h0);

        for (int c = 0; c <= 235; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cyc = c;
            applyStimulus(c);
            #1;
            lv = expLevel(c);
            checkOutput("levelA",   {28'b0, levelA},   {28'b0, lv});
            checkOutput("pressA",   {28'b0, pressA},   {28'b0, expPress(c)});
            checkOutput("releaseA", {28'b0, releaseA}, {28'b0, expRelease(c)});
            checkOutput("longA",    {28'b0, longA},    {28'b0, expLong(c)});
            checkOutput("repeatA",  {28'b0, repeatA},  {28'b0, expRepeat(c)});
            checkOutput("anyA",     {31'b0, anyA},     {31'b0, ~&lv});
            checkOutput("levelB",   {28'b0, levelB},   {28'b0, lv});
            checkOutput("pressB",   {28'b0, pressB},   {28'b0, expPress(c)});
            checkOutput("releaseB", {28'b0, releaseB}, {28'b0, expRelease(c)});
            checkOutput("longB",    {28'b0, longB},    {28'b0, expLong(c)});
            checkOutput("repeatB",  {28'b0, repeatB},  32'h0);
            checkOutput("anyB",     {31'b0, anyB},     {31'b0, ~&lv});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_debounce_bank.md
UART_DEBOUNCE_BANK -- requirements
Module: uart_debounce_bank

Interface
REQ-001 Parameter CLK_FREQ, default 27_000_000: system clock frequency, Hz.
REQ-002 Parameter HOLD_MS, default 5: required input stability time, ms.
REQ-003 Parameter NUM_CH, default 4: number of independent button channels, 1..16.
REQ-004 Parameter LONG_MS, default 1000: pressed time from press commit to long-press event, ms.
REQ-005 Parameter REPEAT_MS, default 200: auto-repeat period after long press, ms; 0 disables repeat.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 btn_raw  input  NUM_CH  raw unsynchronized buttons, active-low (1 = released).
REQ-009 btn_level  output  NUM_CH  debounced level per channel, active-low.
REQ-010 press_pulse  output  NUM_CH  one-cycle pulse on debounced press (1->0).
REQ-011 release_pulse  output  NUM_CH  one-cycle pulse on debounced release (0->1).
REQ-012 long_pulse  output  NUM_CH  one-cycle pulse when the long-press threshold is reached.
REQ-013 repeat_pulse  output  NUM_CH  one-cycle auto-repeat pulse while long-pressed.
REQ-014 any_pressed  output  1  OR of all channels currently debounced-pressed.

Function
REQ-015 Derived constants: HOLD_CYC=(CLK_FREQ/1000)*HOLD_MS, LONG_CYC=(CLK_FREQ/1000)*LONG_MS, REPEAT_CYC=(CLK_FREQ/1000)*REPEAT_MS; counter widths = $clog2(value+1).
REQ-016 Each channel passes btn_raw through a 2-FF synchronizer (s1, s2) before any use.
REQ-017 Debounce counter increments each cycle s2 != btn_level; clears to 0 on any cycle s2 == btn_level (glitch restart).
REQ-018 btn_level takes s2 on the edge where the counter reaches HOLD_CYC-1 (HOLD_CYC consecutive disagreeing samples); the counter clears on the same edge.
REQ-019 Total latency from a clean btn_raw edge to btn_level change is 2+HOLD_CYC cycles.
REQ-020 press_pulse/release_pulse are registered and high exactly in the first cycle btn_level shows the new value.
REQ-021 Per-channel FSM: RELEASED -> PRESSED on press commit; PRESSED -> LONG when the hold timer reaches LONG_CYC; PRESSED or LONG -> RELEASED on release commit.
REQ-022 Hold timer clears on press commit, counts every cycle in PRESSED, and fires long_pulse for one cycle on transition to LONG.
REQ-023 In LONG with REPEAT_MS != 0: repeat_pulse fires every REPEAT_CYC cycles, the first REPEAT_CYC cycles after long_pulse; with REPEAT_MS == 0, repeat_pulse stays 0.
REQ-024 Release in any state: release_pulse asserted, timers cleared, no long/repeat pulse in that cycle or later until the next press.
REQ-025 Timers never wrap; the repeat counter reloads to 0 after each pulse.
REQ-026 Channels are fully independent; simultaneous events on multiple channels each produce their own pulses in the same cycle.
REQ-027 any_pressed is registered, equal to ~&btn_level delayed by 0 cycles (computed from the next-state level).

Reset
REQ-028 On rst: s1, s2, btn_level all 1; all pulses 0; any_pressed 0; counters 0; FSM RELEASED.
REQ-029 rst asserted mid-press clears immediately; after release of rst a held-low input yields press_pulse 2+HOLD_CYC cycles later and restarts the long timer.

Structure
REQ-030 Package uart_debounce_pkg holds the FSM state enum (RELEASED, PRESSED, LONG) and an ms-to-cycles constant function.
REQ-031 Sub-module uart_debounce_chan implements one channel; the top generates NUM_CH instances and the any_pressed OR.

Verification (CLK_FREQ=1000, HOLD_MS=5, LONG_MS=20, REPEAT_MS=8, NUM_CH=4)
REQ-032 ch0 held low from cycle 10 -> btn_level[0]=0 and press_pulse[0] at cycle 17; long_pulse[0] at 37; repeat_pulse[0] at 45, 53, 61.
REQ-033 ch1 low for 3 cycles then high (bounce) -> btn_level[1] stays 1, no pulses.
REQ-034 ch2 low for 12 cycles then released -> press_pulse, then release_pulse 5 cycles after s2 returns high; no long_pulse.
REQ-035 ch0 and ch3 pressed on the same cycle -> identical-cycle press_pulse[0] and press_pulse[3]; any_pressed=1 until both release.
REQ-036 rst pulsed while ch0 is in LONG -> all outputs reset at once; held input re-presses 7 cycles after rst deasserts.
REQ-037 REPEAT_MS=0 rerun of REQ-032 -> long_pulse at 37, no repeat_pulse through cycle 100.
